// File: rtl/tx_report_scheduler_if.sv
// rtl/tx_report_scheduler_if.sv - byte-wide valid/ready link from the report scheduler to the UART transmitter
interface tx_report_scheduler_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;

   modport master (output tx_data, output tx_valid, input tx_ready);
   modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/tx_report_scheduler.sv
// rtl/tx_report_scheduler.sv - streams header, sequence number, snapshot data bytes and optional XOR checksum to the UART
// Optional feature: define TX_CHECKSUM_EN to append the checksum byte.
module tx_report_scheduler #(
   parameter int         NUM_WORDS = 4,
   parameter int         WORD_W    = 16,
   parameter logic [7:0] HEADER    = 8'hA5
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start_tx,
   input  logic [NUM_WORDS*WORD_W-1:0]   data_in,
   tx_report_scheduler_if.master         tx,
   output logic                          busy,
   output logic                          txFinish,
   output logic [7:0]                    seq_num
);
   localparam int BPW    = WORD_W / 8;
   localparam int NBYTES = NUM_WORDS * BPW;
   localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(NBYTES - 1);

   typedef enum logic [2:0] {S_IDLE, S_HDR, S_SEQ, S_DATA, S_CSUM, S_FIN} state_t;

   state_t          state_q, state_d;
   logic [7:0]      tx_data_q, tx_data_d;
   logic            tx_valid_q, tx_valid_d;
   logic            busy_q, busy_d;
   logic            fin_q, fin_d;
   logic [7:0]      seq_q, seq_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [7:0]      snap_q [NBYTES];
   logic [7:0]      snap_d [NBYTES];
   logic [7:0]      snap_load [NBYTES];
   logic [CW-1:0]   nxt_cnt;
   logic            xfer;
   logic            last;

   assign xfer    = tx_valid_q && tx.tx_ready;
   assign last    = (cnt_q == LAST_CNT);
   assign nxt_cnt = cnt_q + 1'b1;

   // Snapshot is stored in transmission order: word 0 first, each word MSB first.
   always_comb begin
      for (int w = 0; w < NUM_WORDS; w++) begin
         for (int b = 0; b < BPW; b++) begin
            snap_load[w*BPW + b] = data_in[w*WORD_W + (BPW-1-b)*8 +: 8];
         end
      end
   end

`ifdef TX_CHECKSUM_EN
   logic [7:0] acc_q, acc_d;
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         tx_data_q  <= 8'h00;
         tx_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         fin_q      <= 1'b0;
         seq_q      <= 8'h00;
         cnt_q      <= '0;
         for (int i = 0; i < NBYTES; i++) snap_q[i] <= 8'h00;
`ifdef TX_CHECKSUM_EN
         acc_q      <= 8'h00;
`endif
      end else begin
         state_q    <= state_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= tx_valid_d;
         busy_q     <= busy_d;
         fin_q      <= fin_d;
         seq_q      <= seq_d;
         cnt_q      <= cnt_d;
         for (int i = 0; i < NBYTES; i++) snap_q[i] <= snap_d[i];
`ifdef TX_CHECKSUM_EN
         acc_q      <= acc_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (start_tx) state_d = S_HDR;
         S_HDR:  if (xfer) state_d = S_SEQ;
         S_SEQ:  if (xfer) state_d = S_DATA;
         S_DATA: begin
            if (xfer && last) begin
`ifdef TX_CHECKSUM_EN
               state_d = S_CSUM;
`else
               state_d = S_FIN;
`endif
            end
         end
         S_CSUM: if (xfer) state_d = S_FIN;
         S_FIN:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      tx_data_d  = tx_data_q;
      tx_valid_d = tx_valid_q;
      fin_d      = 1'b0;
      seq_d      = seq_q;
      cnt_d      = cnt_q;
      busy_d     = (state_d != S_IDLE);
      for (int i = 0; i < NBYTES; i++) snap_d[i] = snap_q[i];
`ifdef TX_CHECKSUM_EN
      acc_d = xfer ? (acc_q ^ tx_data_q) : acc_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start_tx) begin
               for (int i = 0; i < NBYTES; i++) snap_d[i] = snap_load[i];
               tx_data_d  = HEADER;
               tx_valid_d = 1'b1;
               cnt_d      = '0;
`ifdef TX_CHECKSUM_EN
               acc_d      = 8'h00;
`endif
            end
         end
         S_HDR: if (xfer) tx_data_d = seq_q;
         S_SEQ: begin
            if (xfer) begin
               tx_data_d = snap_q[0];
               cnt_d     = '0;
            end
         end
         S_DATA: begin
            if (xfer) begin
               if (last) begin
`ifdef TX_CHECKSUM_EN
                  tx_data_d  = acc_q ^ tx_data_q;
`else
                  tx_data_d  = 8'h00;
                  tx_valid_d = 1'b0;
                  fin_d      = 1'b1;
`endif
               end else begin
                  cnt_d     = nxt_cnt;
                  tx_data_d = snap_q[nxt_cnt];
               end
            end
         end
         S_CSUM: begin
            if (xfer) begin
               tx_data_d  = 8'h00;
               tx_valid_d = 1'b0;
               fin_d      = 1'b1;
            end
         end
         S_FIN: seq_d = seq_q + 8'd1;
         default: ;
      endcase
   end

   assign tx.tx_data  = tx_data_q;
   assign tx.tx_valid = tx_valid_q;
   assign busy        = busy_q;
   assign txFinish    = fin_q;
   assign seq_num     = seq_q;
endmodule

// File: tb/tb_tx_report_scheduler.sv
// tb/tb_tx_report_scheduler.sv - randomized and directed bench with a byte-queue frame model for tx_report_scheduler
module tb_tx_report_scheduler;
   localparam int NW = 2;
   localparam int WW = 16;
   localparam logic [7:0] HDR = 8'hA5;
`ifdef TX_CHECKSUM_EN
   localparam int LEN = 2 + NW*(WW/8) + 1;
`else
   localparam int LEN = 2 + NW*(WW/8);
`endif

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              start_tx = 1'b0;
   logic [NW*WW-1:0]  data_in = '0;
   logic              busy, txFinish;
   logic [7:0]        seq_num;
   tx_report_scheduler_if tx_if();

   tx_report_scheduler #(.NUM_WORDS(NW), .WORD_W(WW), .HEADER(HDR)) dut (
      .clk(clk), .reset(reset), .start_tx(start_tx), .data_in(data_in),
      .tx(tx_if), .busy(busy), .txFinish(txFinish), .seq_num(seq_num)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Frame-level model: a frame is a queue of bytes popped one per accepted transfer.
   int         m_phase = 0;
   logic [7:0] m_q[$];
   logic       m_valid = 0, m_busy = 0, m_fin = 0;
   logic [7:0] m_data = 0, m_seq = 0;

   always @(posedge clk) begin
      if (!reset) begin
         m_phase = 0; m_valid = 0; m_busy = 0; m_fin = 0; m_data = 0; m_seq = 0;
         m_q.delete();
      end else begin
         case (m_phase)
            0: if (start_tx) begin
               logic [7:0] cs;
               logic [NW*WW-1:0] d;
               m_q.delete();
               m_q.push_back(HDR);
               m_q.push_back(m_seq);
               cs = HDR ^ m_seq;
               for (int w = 0; w < NW; w++)
                  for (int b = WW/8 - 1; b >= 0; b--) begin
                     d = data_in >> (w*WW + b*8);
                     m_q.push_back(d[7:0]);
                     cs = cs ^ d[7:0];
                  end
`ifdef TX_CHECKSUM_EN
               m_q.push_back(cs);
`endif
               m_data = m_q.pop_front();
               m_valid = 1; m_busy = 1; m_phase = 1;
            end
            1: if (tx_if.tx_ready) begin
               if (m_q.size() > 0) m_data = m_q.pop_front();
               else begin m_valid = 0; m_fin = 1; m_phase = 2; end
            end
            default: begin m_fin = 0; m_busy = 0; m_seq = m_seq + 8'd1; m_phase = 0; end
         endcase
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("cmp_valid", tx_if.tx_valid, m_valid);
         check("cmp_busy", busy, m_busy);
         check("cmp_finish", txFinish, m_fin);
         check("cmp_seq", seq_num, m_seq);
         if (m_valid) check("cmp_data", tx_if.tx_data, m_data);
      end
   end

   logic [7:0] got[$];
   int fin_cyc, fin_n;

   task automatic run_frame(input int stall_at, input int stall_n, input int pulse_a,
                            input int pulse_b, input bit zero_mid);
      got.delete(); fin_cyc = -1; fin_n = 0;
      @(posedge clk); #1;
      start_tx = 1'b1; data_in = 32'h1234_ABCD; tx_if.tx_ready = 1'b1;
      for (int c = 1; c <= 60; c++) begin
         @(posedge clk); #1;
         start_tx = (c == pulse_a) || (c == pulse_b);
         tx_if.tx_ready = !(c >= stall_at && c < stall_at + stall_n);
         if (zero_mid && c == 4) data_in = '0;
         @(negedge clk);
         if (c >= stall_at && c < stall_at + stall_n)
            check("stall_hold", {tx_if.tx_valid, tx_if.tx_data}, {1'b1, 8'hAB});
         if (tx_if.tx_valid && tx_if.tx_ready) got.push_back(tx_if.tx_data);
         if (txFinish) begin
            fin_n++;
            if (fin_cyc < 0) fin_cyc = c;
         end
         if (fin_cyc >= 0 && c == fin_cyc + 1) break;
      end
      start_tx = 1'b0;
   endtask

   task automatic check_frame(input logic [7:0] seq, input logic [7:0] csum, input int fin_exp);
      logic [7:0] e[$];
      e = '{HDR, seq, 8'hAB, 8'hCD, 8'h12, 8'h34};
`ifdef TX_CHECKSUM_EN
      e.push_back(csum);
`endif
      check("frame_len", got.size(), LEN);
      for (int i = 0; i < LEN; i++)
         check($sformatf("frame_byte%0d", i), (i < got.size()) ? {24'h0, got[i]} : 32'hFFFF, e[i]);
      check("fin_cycle", fin_cyc, fin_exp);
      check("fin_count", fin_n, 1);
   endtask

   task automatic do_reset();
      @(posedge clk); #1; reset = 1'b0; start_tx = 1'b0; tx_if.tx_ready = 1'b1;
      @(posedge clk); #1; reset = 1'b1;
   endtask

   initial begin
      tx_if.tx_ready = 1'b1;
      do_reset();
      chk_en = 1'b1;
      @(negedge clk);
      check("rst_valid", tx_if.tx_valid, 1'b0);
      check("rst_data", tx_if.tx_data, 8'h00);
      check("rst_busy", busy, 1'b0);
      check("rst_finish", txFinish, 1'b0);
      check("rst_seq", seq_num, 8'h00);

      run_frame(0, 0, 4, LEN + 1, 1'b0);
      check_frame(8'h00, 8'hE5, LEN + 1);
      run_frame(0, 0, 0, 0, 1'b0);
      check_frame(8'h01, 8'hE4, LEN + 1);
      check("seq_after_two", seq_num, 8'h02);
      run_frame(3, 3, 0, 0, 1'b1);
      check_frame(8'h02, 8'hE7, LEN + 4);

      // Reset pulse while the data bytes are being sent.
      @(posedge clk); #1; start_tx = 1'b1; data_in = 32'h1234_ABCD;
      for (int c = 1; c <= 4; c++) begin
         @(posedge clk); #1; start_tx = 1'b0;
      end
      reset = 1'b0;
      @(posedge clk); #1; reset = 1'b1;
      @(negedge clk);
      check("midrst_valid", tx_if.tx_valid, 1'b0);
      check("midrst_busy", busy, 1'b0);
      check("midrst_seq", seq_num, 8'h00);
      fin_n = 0;
      for (int c = 0; c < 15; c++) begin
         if (txFinish) fin_n++;
         @(negedge clk);
      end
      check("midrst_no_finish", fin_n, 0);
      run_frame(0, 0, 0, 0, 1'b0);
      check_frame(8'h00, 8'hE5, LEN + 1);

      do_reset();
      for (int f = 1; f <= 257; f++) begin
         run_frame(0, 0, 0, 0, 1'b0);
         if (f == 256) check("wrap_ff", (got.size() > 1) ? {24'h0, got[1]} : 32'hFFFF, 8'hFF);
         if (f == 257) check("wrap_00", (got.size() > 1) ? {24'h0, got[1]} : 32'hFFFF, 8'h00);
      end

      for (int c = 0; c < 4000; c++) begin
         @(posedge clk); #1;
         start_tx = ($urandom_range(0, 7) == 0);
         tx_if.tx_ready = ($urandom_range(0, 3) != 0);
         data_in = {$urandom()};
         reset = ($urandom_range(0, 299) != 0);
      end
      @(posedge clk); #1; reset = 1'b1; start_tx = 1'b0;
      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
